// File: rtl/ex_issue_if.sv
// rtl/ex_issue_if.sv - issue-stage bus: decoded instruction in, ALU drive/return, completion out
// Purpose: bundles every ex_issue signal except clk/reset.
// Modports: slave = ex_issue side, master = issuer/ALU/testbench side.
interface ex_issue_if;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  in_op;
   logic [5:0]  in_func;
   logic [31:0] in_rs_val;
   logic [31:0] in_rt_val;
   logic [15:0] in_imm;
   logic [4:0]  in_rd;
   logic [31:0] alu_data_a;
   logic [31:0] alu_data_b;
   logic [2:0]  alu_control;
   logic [5:0]  alu_func;
   logic [31:0] alu_result;
   logic [2:0]  alu_flag;
   logic        alu_branch;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        br_valid;
   logic        br_taken;
   logic [31:0] br_target;
   logic [2:0]  flag_q;
   logic        exc;

   modport slave (
      input  in_valid, in_op, in_func, in_rs_val, in_rt_val, in_imm, in_rd,
      input  alu_result, alu_flag, alu_branch,
      output in_ready, alu_data_a, alu_data_b, alu_control, alu_func,
      output wb_valid, wb_rd, wb_data, br_valid, br_taken, br_target, flag_q, exc
   );

   modport master (
      output in_valid, in_op, in_func, in_rs_val, in_rt_val, in_imm, in_rd,
      output alu_result, alu_flag, alu_branch,
      input  in_ready, alu_data_a, alu_data_b, alu_control, alu_func,
      input  wb_valid, wb_rd, wb_data, br_valid, br_taken, br_target, flag_q, exc
   );
endinterface

// File: rtl/ex_issue.sv
// rtl/ex_issue.sv - single-issue execute stage driving an external multi-cycle ALU
// Purpose: decodes one instruction at a time, drives the ALU with registered operands,
//          waits the op's settle time, then emits writeback / branch / exception pulses.
// Ports:   clk   - rising-edge clock
//          reset - synchronous, active-low
//          bus   - ex_issue_if.slave (instruction handshake, ALU drive/return, completion)
module ex_issue #(
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 8
) (
   input logic   clk,
   input logic   reset,
   ex_issue_if.slave bus
);
   localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          in_ready_c, accept, sample;

   // decode results
   logic [2:0]    dec_ctrl;
   logic [5:0]    dec_func;
   logic [31:0]   dec_b;
   logic          dec_wb, dec_flag, dec_br, dec_ill, dec_div;
   logic [CW-1:0] dec_cnt;

   // registered instruction
   logic [31:0]   alu_a_q, alu_b_q;
   logic [2:0]    alu_ctrl_q;
   logic [5:0]    alu_func_q;
   logic [4:0]    rd_q;
   logic          wb_en_q, flag_en_q, br_q, ill_q, div_q;

   // completion outputs
   logic          wb_valid_q, br_valid_q, exc_q, br_taken_q;
   logic [4:0]    wb_rd_q;
   logic [31:0]   wb_data_q, br_target_q;
   logic [2:0]    flag_q;

   always_comb begin
      dec_ctrl = 3'b111;
      dec_func = 6'b000000;
      dec_b    = bus.in_rt_val;
      dec_wb   = 1'b0;
      dec_flag = 1'b0;
      dec_br   = 1'b0;
      dec_ill  = 1'b1;
      dec_div  = 1'b0;
      dec_cnt  = '0;
      case (bus.in_op)
         6'b000000: begin
            dec_func = bus.in_func;
            case (bus.in_func)
               6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111,
               6'b000010, 6'b000001: begin
                  dec_ctrl = 3'b010;
                  dec_ill  = 1'b0;
                  dec_wb   = 1'b1;
                  dec_flag = 1'b1;
                  if (bus.in_func == 6'b000010) dec_cnt = CW'(MUL_CYCLES - 1);
                  if (bus.in_func == 6'b000001) begin
                     dec_cnt = CW'(DIV_CYCLES - 1);
                     dec_div = 1'b1;
                  end
               end
               default: ;
            endcase
         end
         6'b001000, 6'b001001: begin
            dec_ctrl = (bus.in_op == 6'b001000) ? 3'b000 : 3'b001;
            dec_b    = {{16{bus.in_imm[15]}}, bus.in_imm};
            dec_ill  = 1'b0;
            dec_wb   = 1'b1;
            dec_flag = 1'b1;
         end
         6'b001100, 6'b001101: begin
            dec_ctrl = (bus.in_op == 6'b001100) ? 3'b011 : 3'b100;
            dec_b    = {16'h0000, bus.in_imm};
            dec_ill  = 1'b0;
            dec_wb   = 1'b1;
         end
         6'b010000: begin
            dec_ctrl = 3'b101;
            dec_b    = {{16{bus.in_imm[15]}}, bus.in_imm};
            dec_ill  = 1'b0;
            dec_br   = 1'b1;
         end
         6'b010001: begin
            dec_ctrl = 3'b110;
            dec_ill  = 1'b0;
            dec_flag = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: if (accept) begin
            state_d = S_EXEC;
            cnt_d   = dec_cnt;
         end
         S_EXEC: if (cnt_q == '0) state_d = S_DONE;
                 else             cnt_d   = cnt_q - CW'(1);
         S_DONE: if (accept) begin
            state_d = S_EXEC;
            cnt_d   = dec_cnt;
         end else begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready_c = (state_q != S_EXEC);
      accept     = bus.in_valid && in_ready_c;
      sample     = (state_q == S_EXEC) && (cnt_q == '0);
   end

   // Pulses are set on the sampling edge, so they are high exactly during DONE.
   always_ff @(posedge clk) begin
      if (!reset) begin
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_ctrl_q  <= '0;
         alu_func_q  <= '0;
         rd_q        <= '0;
         wb_en_q     <= 1'b0;
         flag_en_q   <= 1'b0;
         br_q        <= 1'b0;
         ill_q       <= 1'b0;
         div_q       <= 1'b0;
         wb_valid_q  <= 1'b0;
         br_valid_q  <= 1'b0;
         exc_q       <= 1'b0;
         br_taken_q  <= 1'b0;
         wb_rd_q     <= '0;
         wb_data_q   <= '0;
         br_target_q <= '0;
         flag_q      <= '0;
      end else begin
         wb_valid_q <= 1'b0;
         br_valid_q <= 1'b0;
         exc_q      <= 1'b0;
         if (accept) begin
            alu_a_q    <= bus.in_rs_val;
            alu_b_q    <= dec_b;
            alu_ctrl_q <= dec_ctrl;
            alu_func_q <= dec_func;
            rd_q       <= bus.in_rd;
            wb_en_q    <= dec_wb;
            flag_en_q  <= dec_flag;
            br_q       <= dec_br;
            ill_q      <= dec_ill;
            div_q      <= dec_div;
         end
         if (sample) begin
            if (ill_q) begin
               exc_q <= 1'b1;
            end else if (div_q && bus.alu_flag == 3'b010) begin
               // divide by zero: raise exception instead of writing back
               exc_q  <= 1'b1;
               flag_q <= bus.alu_flag;
            end else begin
               if (flag_en_q) flag_q <= bus.alu_flag;
               if (wb_en_q) begin
                  wb_valid_q <= 1'b1;
                  wb_rd_q    <= rd_q;
                  wb_data_q  <= bus.alu_result;
               end
               if (br_q) begin
                  br_valid_q  <= 1'b1;
                  br_taken_q  <= bus.alu_branch;
                  br_target_q <= bus.alu_result;
               end
            end
         end
      end
   end

   assign bus.in_ready    = in_ready_c;
   assign bus.alu_data_a  = alu_a_q;
   assign bus.alu_data_b  = alu_b_q;
   assign bus.alu_control = alu_ctrl_q;
   assign bus.alu_func    = alu_func_q;
   assign bus.wb_valid    = wb_valid_q;
   assign bus.wb_rd       = wb_rd_q;
   assign bus.wb_data     = wb_data_q;
   assign bus.br_valid    = br_valid_q;
   assign bus.br_taken    = br_taken_q;
   assign bus.br_target   = br_target_q;
   assign bus.flag_q      = flag_q;
   assign bus.exc         = exc_q;
endmodule

// File: tb/tb_ex_issue.sv
// tb/tb_ex_issue.sv - self-checking bench for ex_issue with a behavioural ALU and completion scoreboard
module tb_ex_issue;
   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_bad = 0;

   ex_issue_if bus ();
   ex_issue #(.MUL_CYCLES(4), .DIV_CYCLES(8)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   typedef struct {
      logic [5:0]  op;
      logic [5:0]  func;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [15:0] imm;
      logic [4:0]  rd;
      logic [2:0]  ctrl;
      logic [31:0] b;
      logic        wb;
      logic [31:0] data;
      logic        br;
      logic        taken;
      logic        ex;
      logic [2:0]  flag;
      int          lat;
   } vec_t;

   typedef struct {
      vec_t v;
      int   acc;
   } sb_t;

   sb_t  sb[$];
   sb_t  mon_e;
   vec_t tbl[17];

   // behavioural ALU
   logic [31:0] alu_a, alu_b, alu_r;
   logic [2:0]  alu_f;
   logic        alu_br;

   function automatic logic [2:0] fl_add(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r);
      if (a[31] == b[31] && r[31] != a[31]) return 3'b011;
      return (r == 32'd0) ? 3'b001 : 3'b000;
   endfunction

   function automatic logic [2:0] fl_sub(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r);
      if (a[31] != b[31] && r[31] != a[31]) return 3'b100;
      return (r == 32'd0) ? 3'b001 : 3'b000;
   endfunction

   always_comb begin
      alu_a  = bus.alu_data_a;
      alu_b  = bus.alu_data_b;
      alu_r  = 32'd0;
      alu_f  = 3'b000;
      alu_br = 1'b0;
      case (bus.alu_control)
         3'b000: begin alu_r = alu_a + alu_b; alu_f = fl_add(alu_a, alu_b, alu_r); end
         3'b001: begin alu_r = alu_a - alu_b; alu_f = fl_sub(alu_a, alu_b, alu_r); end
         3'b010: begin
            case (bus.alu_func)
               6'b100000: begin alu_r = alu_a + alu_b; alu_f = fl_add(alu_a, alu_b, alu_r); end
               6'b100010: begin alu_r = alu_a - alu_b; alu_f = fl_sub(alu_a, alu_b, alu_r); end
               6'b000010: begin alu_r = alu_a * alu_b; alu_f = (alu_r == 0) ? 3'b001 : 3'b000; end
               6'b000001: begin
                  if (alu_b == 32'd0) alu_f = 3'b010;
                  else begin alu_r = alu_a / alu_b; alu_f = (alu_r == 0) ? 3'b001 : 3'b000; end
               end
               6'b100100: begin alu_r = alu_a & alu_b; alu_f = (alu_r == 0) ? 3'b001 : 3'b000; end
               6'b100101: begin alu_r = alu_a | alu_b; alu_f = (alu_r == 0) ? 3'b001 : 3'b000; end
               6'b100111: begin alu_r = ~alu_a;        alu_f = (alu_r == 0) ? 3'b001 : 3'b000; end
               default: ;
            endcase
         end
         3'b011: alu_r = alu_a & alu_b;
         3'b100: alu_r = alu_a | alu_b;
         3'b101: begin alu_r = alu_a; alu_br = ~alu_b[0]; end
         3'b110: begin alu_r = alu_a - alu_b; alu_f = (alu_a == alu_b) ? 3'b001 : 3'b000; end
         default: ;
      endcase
      bus.alu_result = alu_r;
      bus.alu_flag   = alu_f;
      bus.alu_branch = alu_br;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [5:0] op, input logic [5:0] func, input logic [31:0] rs,
                               input logic [31:0] rt, input logic [15:0] imm, input logic [4:0] rd,
                               input logic [2:0] ctrl, input logic [31:0] b, input logic wb,
                               input logic [31:0] data, input logic br, input logic taken,
                               input logic ex, input logic [2:0] flag, input int lat);
      vec_t v;
      v.op = op; v.func = func; v.rs = rs; v.rt = rt; v.imm = imm; v.rd = rd;
      v.ctrl = ctrl; v.b = b; v.wb = wb; v.data = data; v.br = br; v.taken = taken;
      v.ex = ex; v.flag = flag; v.lat = lat;
      return v;
   endfunction

   // completion monitor: every pulse must match the oldest outstanding instruction
   always @(negedge clk) begin
      if (bus.wb_valid || bus.br_valid || bus.exc) begin
         if (sb.size() == 0) begin
            chk("unexpected_pulse", {29'd0, bus.wb_valid, bus.br_valid, bus.exc}, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("latency",  cyc - mon_e.acc, mon_e.v.lat);
            chk("wb_valid", bus.wb_valid, mon_e.v.wb);
            chk("br_valid", bus.br_valid, mon_e.v.br);
            chk("exc",      bus.exc,      mon_e.v.ex);
            if (mon_e.v.wb) begin
               chk("wb_rd",   bus.wb_rd,   mon_e.v.rd);
               chk("wb_data", bus.wb_data, mon_e.v.data);
            end
            if (mon_e.v.br) begin
               chk("br_taken",  bus.br_taken,  mon_e.v.taken);
               chk("br_target", bus.br_target, mon_e.v.data);
            end
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic drive_wait(input vec_t v, input bit push, output int acc);
      int  guard;
      sb_t e;
      bus.in_op     = v.op;
      bus.in_func   = v.func;
      bus.in_rs_val = v.rs;
      bus.in_rt_val = v.rt;
      bus.in_imm    = v.imm;
      bus.in_rd     = v.rd;
      bus.in_valid  = 1'b1;
      guard = 0;
      while (!bus.in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      acc = cyc + 1;
      if (!bus.in_ready) begin
         chk("accept_timeout", bus.in_ready, 1);
         return;
      end
      if (push && (v.wb || v.br || v.ex)) begin
         e.v = v;
         e.acc = acc;
         sb.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic run(input vec_t v, input string tag);
      int acc;
      drive_wait(v, 1'b1, acc);
      bus.in_valid = 1'b0;
      chk({tag, ".alu_control"}, bus.alu_control, v.ctrl);
      chk({tag, ".alu_data_a"},  bus.alu_data_a,  v.rs);
      chk({tag, ".alu_data_b"},  bus.alu_data_b,  v.b);
      if (v.ctrl != 3'b111) chk({tag, ".alu_func"}, bus.alu_func, (v.op == 6'd0) ? v.func : 6'd0);
      for (int i = 0; i < v.lat; i++) begin
         chk({tag, ".busy"}, bus.in_ready, 1'b0);
         @(negedge clk);
      end
      chk({tag, ".ready"}, bus.in_ready, 1'b1);
      chk({tag, ".flag_q"}, bus.flag_q, v.flag);
      @(negedge clk);
   endtask

   initial begin
      int   a1, a2, ad;
      vec_t vadd, vsub, vdiv;

      //          op        func      rs            rt          imm       rd  ctrl    b             wb data          br tk ex flag    lat
      tbl[0]  = mk(6'b001000, 6'd0,     32'd5,        32'd0,      16'hFFFF, 3,  3'b000, 32'hFFFFFFFF, 1, 32'd4,        0, 0, 0, 3'b000, 1);
      tbl[1]  = mk(6'b001001, 6'd0,     32'd7,        32'd0,      16'd7,    5,  3'b001, 32'd7,        1, 32'd0,        0, 0, 0, 3'b001, 1);
      tbl[2]  = mk(6'b001101, 6'd0,     32'h0000F000, 32'd0,      16'h8001, 4,  3'b100, 32'h00008001, 1, 32'h0000F001, 0, 0, 0, 3'b001, 1);
      tbl[3]  = mk(6'b001100, 6'd0,     32'hFFFF1234, 32'd0,      16'hF0F0, 6,  3'b011, 32'h0000F0F0, 1, 32'h00001030, 0, 0, 0, 3'b001, 1);
      tbl[4]  = mk(6'b000000, 6'b000010,32'd3,        32'd7,      16'd0,    7,  3'b010, 32'd7,        1, 32'd21,       0, 0, 0, 3'b000, 4);
      tbl[5]  = mk(6'b000000, 6'b000001,32'd3,        32'd0,      16'd0,    8,  3'b010, 32'd0,        0, 32'd0,        0, 0, 1, 3'b010, 8);
      tbl[6]  = mk(6'b000000, 6'b000001,32'd100,      32'd7,      16'd0,    9,  3'b010, 32'd7,        1, 32'd14,       0, 0, 0, 3'b000, 8);
      tbl[7]  = mk(6'b010001, 6'd0,     32'd9,        32'd9,      16'd0,    0,  3'b110, 32'd9,        0, 32'd0,        0, 0, 0, 3'b001, 1);
      tbl[8]  = mk(6'b010000, 6'd0,     32'h400,      32'd0,      16'd1,    0,  3'b101, 32'd1,        0, 32'h400,      1, 0, 0, 3'b001, 1);
      tbl[9]  = mk(6'b010000, 6'd0,     32'h1234,     32'd0,      16'hFFFE, 0,  3'b101, 32'hFFFFFFFE, 0, 32'h1234,     1, 1, 0, 3'b001, 1);
      tbl[10] = mk(6'b000000, 6'b100000,32'h7FFFFFFF, 32'd1,      16'd0,    10, 3'b010, 32'd1,        1, 32'h80000000, 0, 0, 0, 3'b011, 1);
      tbl[11] = mk(6'b000000, 6'b100010,32'h80000000, 32'd1,      16'd0,    11, 3'b010, 32'd1,        1, 32'h7FFFFFFF, 0, 0, 0, 3'b100, 1);
      tbl[12] = mk(6'b111111, 6'd0,     32'd1,        32'd2,      16'd0,    12, 3'b111, 32'd2,        0, 32'd0,        0, 0, 1, 3'b100, 1);
      tbl[13] = mk(6'b000000, 6'b111111,32'd1,        32'd2,      16'd0,    13, 3'b111, 32'd2,        0, 32'd0,        0, 0, 1, 3'b100, 1);
      tbl[14] = mk(6'b000000, 6'b100100,32'hF0,       32'h3C,     16'd0,    14, 3'b010, 32'h3C,       1, 32'h30,       0, 0, 0, 3'b000, 1);
      tbl[15] = mk(6'b000000, 6'b100101,32'hF0,       32'h0F,     16'd0,    15, 3'b010, 32'h0F,       1, 32'hFF,       0, 0, 0, 3'b000, 1);
      tbl[16] = mk(6'b000000, 6'b100111,32'd0,        32'd0,      16'd0,    16, 3'b010, 32'd0,        1, 32'hFFFFFFFF, 0, 0, 0, 3'b000, 1);
      vadd = mk(6'b000000, 6'b100000, 32'd10, 32'd3, 16'd0, 1, 3'b010, 32'd3, 1, 32'd13, 0, 0, 0, 3'b000, 1);
      vsub = mk(6'b000000, 6'b100010, 32'd10, 32'd3, 16'd0, 2, 3'b010, 32'd3, 1, 32'd7,  0, 0, 0, 3'b000, 1);
      vdiv = mk(6'b000000, 6'b000001, 32'd50, 32'd5, 16'd0, 20, 3'b010, 32'd5, 1, 32'd10, 0, 0, 0, 3'b000, 8);

      reset = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_op = '0; bus.in_func = '0; bus.in_rs_val = '0;
      bus.in_rt_val = '0; bus.in_imm = '0; bus.in_rd = '0;
      repeat (3) @(negedge clk);
      chk("rst.in_ready",    bus.in_ready,    1'b1);
      chk("rst.wb_valid",    bus.wb_valid,    1'b0);
      chk("rst.exc",         bus.exc,         1'b0);
      chk("rst.flag_q",      bus.flag_q,      3'b000);
      chk("rst.alu_control", bus.alu_control, 3'b000);
      chk("rst.wb_data",     bus.wb_data,     32'd0);

      // first accept on the very first edge with reset released
      reset = 1'b1;
      for (int i = 0; i < 17; i++) run(tbl[i], $sformatf("v%0d", i));

      // back-to-back: second instruction accepted in DONE of the first
      drive_wait(vadd, 1'b1, a1);
      drive_wait(vsub, 1'b1, a2);
      bus.in_valid = 1'b0;
      chk("b2b.accept_gap", a2 - a1, 2);
      repeat (4) @(negedge clk);

      run(tbl[7], "cmp2");

      // reset during DIV execution drops it
      drive_wait(vdiv, 1'b0, ad);
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("mid.busy", bus.in_ready, 1'b0);
      reset = 1'b0;
      @(negedge clk);
      chk("mid.in_ready",   bus.in_ready,   1'b1);
      chk("mid.flag_q",     bus.flag_q,     3'b000);
      chk("mid.wb_data",    bus.wb_data,    32'd0);
      chk("mid.wb_rd",      bus.wb_rd,      5'd0);
      chk("mid.alu_data_a", bus.alu_data_a, 32'd0);
      chk("mid.alu_data_b", bus.alu_data_b, 32'd0);
      chk("mid.br_target",  bus.br_target,  32'd0);
      chk("mid.pulses",     {bus.wb_valid, bus.br_valid, bus.exc}, 3'b000);
      reset = 1'b1;
      repeat (12) @(negedge clk);
      run(tbl[0], "post_rst");

      repeat (3) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
